// File: rtl/accum_pkg.sv
// Shared widths and FSM state encoding for the frame accumulator.
package accum_pkg;

  localparam int ACC_WIDTH   = 16;
  localparam int COUNT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DONE
  } accum_state_t;

endpackage

// File: rtl/adder_16bit.sv
// 16-bit unsigned ripple-free adder; overflow is the carry out of bit 15.
module adder_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        carry_in,
  output logic [15:0] sum,
  output logic        overflow
);

  assign {overflow, sum} = {1'b0, a} + {1'b0, b} + {16'd0, carry_in};

endmodule

// File: rtl/accumulate_16bit.sv
// Frame accumulator: sums NUM_SAMPLES unsigned samples through adder_16bit and
// presents the total plus a sticky carry flag on a valid/ack handshake.
module accumulate_16bit
  import accum_pkg::*;
#(
  parameter int NUM_SAMPLES = 4,
  parameter bit SATURATE    = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [ACC_WIDTH-1:0]   data_in,
  input  logic                   data_valid,
  output logic                   data_ready,
  output logic [ACC_WIDTH-1:0]   result,
  output logic                   overflow_flag,
  output logic                   result_valid,
  input  logic                   result_ack,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] sample_count
);

  localparam logic [COUNT_WIDTH-1:0] LAST_COUNT = COUNT_WIDTH'(NUM_SAMPLES - 1);

  accum_state_t           state, state_next;
  logic [ACC_WIDTH-1:0]   acc;
  logic [ACC_WIDTH-1:0]   sum;
  logic                   carry;
  logic                   ovf;
  logic [COUNT_WIDTH-1:0] count;
  logic                   accept;

  adder_16bit u_adder (
    .a        (acc),
    .b        (data_in),
    .carry_in (1'b0),
    .sum      (sum),
    .overflow (carry)
  );

  assign accept = (state == ACCUM) && data_valid;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_next   = state;
    data_ready   = 1'b0;
    result_valid = 1'b0;
    busy         = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_next = ACCUM;
      end
      ACCUM: begin
        data_ready = 1'b1;
        busy       = 1'b1;
        if (accept && (count == LAST_COUNT)) state_next = DONE;
      end
      DONE: begin
        result_valid = 1'b1;
        busy         = 1'b1;
        if (result_ack) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      state <= state_next;
      if ((state == IDLE) && start) begin
        acc   <= '0;
        ovf   <= 1'b0;
        count <= '0;
      end else if (accept) begin
        // Saturation pins the total at full scale; later carries keep it there.
        acc   <= (SATURATE && carry) ? '1 : sum;
        ovf   <= ovf | carry;
        count <= count + COUNT_WIDTH'(1);
      end
    end
  end

  assign result        = acc;
  assign overflow_flag = ovf;
  assign sample_count  = count;

endmodule
